// File: rtl/serial_bus_responder_if.sv
// Serial link and local register bus signals of the target-side responder.
// The slave modport is the responder, the master modport is the link/bus environment.
interface serial_bus_responder_if;
  logic        serialin;
  logic        serialout;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] wrdata;
  logic [15:0] rddata;
  logic [15:0] rdcount;
  logic [15:0] wrcount;
  logic [15:0] bytecount;

  modport slave (
    input  serialin, rddata,
    output serialout, wr, addr, wrdata, rdcount, wrcount, bytecount
  );

  modport master (
    output serialin, rddata,
    input  serialout, wr, addr, wrdata, rdcount, wrcount, bytecount
  );
endinterface

// File: rtl/serial_bus_responder.sv
// Target-side serial bus responder: deserialises 12-bit command frames, runs one
// 16-bit register read or write, and answers with data hi, data lo and status frames.
module serial_bus_responder #(
  parameter int unsigned GAP    = 2,
  parameter int unsigned NBYTES = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_bus_responder_if.slave bus
);
  // state | meaning
  // IDLE  | no response in flight; starts pending or just-completed command
  // EXEC  | address on bus, write strobe high for writes
  // LOAD  | read data sampled, first response frame launched
  // SEND  | shifting a response frame out, k = 0 hi, 1 lo, 2 status
  // GAP   | idle zeros after a frame
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_LOAD, S_SEND, S_GAP} state_t;

  state_t      state;
  logic        sin_q;
  logic [11:0] rx_sr;
  logic [31:0] word_q;
  logic [2:0]  byte_cnt;

  logic        pend_v, pend_rd, pend_wr;
  logic [7:0]  pend_status;
  logic [15:0] pend_addr, pend_wdata;

  logic        cur_rd;
  logic [7:0]  cur_status;
  logic [15:0] resp_data;
  logic [1:0]  k;
  logic [3:0]  bit_cnt, gap_cnt;
  logic [10:0] tx_sr;

  logic        serialout_q, wr_q;
  logic [15:0] addr_q, wrdata_q, rdcount_q, wrcount_q, bytecount_q;

  logic        frame_done, cmd_done, go;
  logic [39:0] word_next;
  logic [2:0]  cnt_next;
  logic        dec_rd, dec_wr;
  logic [7:0]  dec_status;
  logic        sel_rd, sel_wr;
  logic [7:0]  sel_status;
  logic [15:0] sel_addr, sel_wdata;
  logic [15:0] resp_next;
  logic        nxt_last;
  logic [7:0]  nxt_byte;
  logic [10:0] nxt_frame;

  assign frame_done = rx_sr[11] && (rx_sr[1:0] == 2'b00);
  assign cmd_done   = frame_done && rx_sr[10];
  assign word_next  = {word_q, rx_sr[9:2]};
  assign cnt_next   = (byte_cnt == 3'd7) ? 3'd7 : byte_cnt + 3'd1;

  always_comb begin
    dec_rd     = 1'b0;
    dec_wr     = 1'b0;
    dec_status = 8'h40;
    if (32'(cnt_next) != NBYTES) begin
      dec_status = 8'h80;
    end else if (word_next[39:32] == 8'h01) begin
      dec_rd     = 1'b1;
      dec_status = 8'h01;
    end else if (word_next[39:32] == 8'h02) begin
      dec_wr     = 1'b1;
      dec_status = 8'h02;
    end
  end

  // A pending command always runs before one completing in the same idle cycle.
  assign go         = (state == S_IDLE) && (pend_v || cmd_done);
  assign sel_rd     = pend_v ? pend_rd     : dec_rd;
  assign sel_wr     = pend_v ? pend_wr     : dec_wr;
  assign sel_status = pend_v ? pend_status : dec_status;
  assign sel_addr   = pend_v ? pend_addr   : word_next[31:16];
  assign sel_wdata  = pend_v ? pend_wdata  : word_next[15:0];

  assign resp_next = cur_rd ? bus.rddata : resp_data;

  always_comb begin
    nxt_last = 1'b0;
    nxt_byte = cur_status;
    if (state == S_LOAD) begin
      nxt_byte = resp_next[15:8];
    end else if (k == 2'd0) begin
      nxt_byte = resp_data[7:0];
    end else begin
      nxt_last = 1'b1;
    end
    nxt_frame = {nxt_last, nxt_byte, 2'b00};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      sin_q       <= 1'b0;
      rx_sr       <= '0;
      word_q      <= '0;
      byte_cnt    <= '0;
      pend_v      <= 1'b0;
      pend_rd     <= 1'b0;
      pend_wr     <= 1'b0;
      pend_status <= '0;
      pend_addr   <= '0;
      pend_wdata  <= '0;
      cur_rd      <= 1'b0;
      cur_status  <= '0;
      resp_data   <= '0;
      k           <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      tx_sr       <= '0;
      serialout_q <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wrdata_q    <= '0;
      rdcount_q   <= '0;
      wrcount_q   <= '0;
      bytecount_q <= '0;
    end else begin
      sin_q <= bus.serialin;
      wr_q  <= 1'b0;

      if (frame_done) begin
        rx_sr       <= '0;
        bytecount_q <= bytecount_q + 16'd1;
        if (rx_sr[10]) begin
          word_q   <= '0;
          byte_cnt <= '0;
        end else begin
          word_q   <= word_next[31:0];
          byte_cnt <= cnt_next;
        end
      end else begin
        rx_sr <= {rx_sr[10:0], sin_q};
      end

      if (cmd_done && (state != S_IDLE || pend_v)) begin
        pend_v      <= 1'b1;
        pend_rd     <= dec_rd;
        pend_wr     <= dec_wr;
        pend_addr   <= word_next[31:16];
        pend_wdata  <= word_next[15:0];
        pend_status <= (pend_v && state != S_IDLE) ? (dec_status | 8'h20) : dec_status;
      end else if (go) begin
        pend_v <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (go) begin
            if (sel_rd || sel_wr) addr_q <= sel_addr;
            if (sel_wr) begin
              wrdata_q  <= sel_wdata;
              wr_q      <= 1'b1;
              wrcount_q <= wrcount_q + 16'd1;
            end
            cur_rd     <= sel_rd;
            cur_status <= sel_status;
            resp_data  <= sel_wr ? sel_wdata : 16'h0000;
            state      <= S_EXEC;
          end
        end
        S_EXEC: state <= S_LOAD;
        S_LOAD: begin
          if (cur_rd) rdcount_q <= rdcount_q + 16'd1;
          resp_data   <= resp_next;
          serialout_q <= 1'b1;
          tx_sr       <= nxt_frame;
          bit_cnt     <= 4'd11;
          k           <= 2'd0;
          state       <= S_SEND;
        end
        S_SEND: begin
          if (bit_cnt != 4'd0) begin
            serialout_q <= tx_sr[10];
            tx_sr       <= {tx_sr[9:0], 1'b0};
            bit_cnt     <= bit_cnt - 4'd1;
          end else if (GAP != 0) begin
            serialout_q <= 1'b0;
            gap_cnt     <= 4'(GAP - 1);
            state       <= S_GAP;
          end else if (k == 2'd2) begin
            serialout_q <= 1'b0;
            state       <= S_IDLE;
          end else begin
            serialout_q <= 1'b1;
            tx_sr       <= nxt_frame;
            bit_cnt     <= 4'd11;
            k           <= k + 2'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
          end else if (k == 2'd2) begin
            state <= S_IDLE;
          end else begin
            serialout_q <= 1'b1;
            tx_sr       <= nxt_frame;
            bit_cnt     <= 4'd11;
            k           <= k + 2'd1;
            state       <= S_SEND;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.serialout = serialout_q;
  assign bus.wr        = wr_q;
  assign bus.addr      = addr_q;
  assign bus.wrdata    = wrdata_q;
  assign bus.rdcount   = rdcount_q;
  assign bus.wrcount   = wrcount_q;
  assign bus.bytecount = bytecount_q;
endmodule

// File: tb/tb_serial_bus_responder.sv
// Directed bench for serial_bus_responder: sends command frames, decodes the
// response line and the write strobe, and compares against hand-computed values.
module tb_serial_bus_responder;
  localparam int GAP_TB  = 15;
  localparam int FSTRIDE = 12 + GAP_TB;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  serial_bus_responder_if bus();

  serial_bus_responder #(.GAP(GAP_TB), .NBYTES(5)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // register file stand-in
  assign bus.rddata = (bus.addr == 16'h1234) ? 16'hBEEF : ~bus.addr;

  int         q_t[$];
  logic [7:0] q_b[$];
  logic       q_l[$];
  int         w_t[$];
  logic [15:0] w_a[$];
  logic [15:0] w_d[$];

  int          rx_n = 0;
  int          rx_t0 = 0;
  logic [11:0] rx_sh = '0;

  always @(negedge clk) begin
    if (rst) begin
      rx_n = 0;
    end else if (rx_n == 0) begin
      if (bus.serialout === 1'b1) begin
        rx_n  = 1;
        rx_sh = 12'h001;
        rx_t0 = cyc;
      end
    end else begin
      rx_sh = {rx_sh[10:0], bus.serialout};
      rx_n++;
      if (rx_n == 12) begin
        q_t.push_back(rx_t0);
        q_b.push_back(rx_sh[9:2]);
        q_l.push_back(rx_sh[10]);
        rx_n = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.wr === 1'b1) begin
      w_t.push_back(cyc);
      w_a.push_back(bus.addr);
      w_d.push_back(bus.wrdata);
    end
  end

  task automatic clear_q();
    q_t.delete(); q_b.delete(); q_l.delete();
    w_t.delete(); w_a.delete(); w_d.delete();
  endtask

  // t returns the cycle in which the responder sees the last frame complete
  task automatic send_cmd(input logic [39:0] b, input int n, output int t);
    logic [11:0] f;
    int c0;
    c0 = 0;
    for (int i = 0; i < n; i++) begin
      f = {1'b1, (i == n - 1), b[39 - 8*i -: 8], 2'b00};
      for (int j = 11; j >= 0; j--) begin
        @(negedge clk);
        bus.serialin = f[j];
        if (j == 11) c0 = cyc;
      end
      @(negedge clk);
      bus.serialin = 1'b0;
    end
    t = c0 + 13;
  endtask

  task automatic wait_frames(input int n, input string name);
    int g;
    g = 0;
    while (q_b.size() < n && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (q_b.size() < n) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: frames got %0d want %0d", name, q_b.size(), n);
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.serialin = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.serialout !== 1'b0) begin miscompares++; $display("FAIL reset_serialout got %b want 0", bus.serialout); end
    vectors++; if (bus.wr !== 1'b0) begin miscompares++; $display("FAIL reset_wr got %b want 0", bus.wr); end
    vectors++; if (bus.addr !== 16'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0000", bus.addr); end
    vectors++; if (bus.wrdata !== 16'h0) begin miscompares++; $display("FAIL reset_wrdata got %h want 0000", bus.wrdata); end
    vectors++; if (bus.rdcount !== 16'h0) begin miscompares++; $display("FAIL reset_rdcount got %h want 0000", bus.rdcount); end
    vectors++; if (bus.wrcount !== 16'h0) begin miscompares++; $display("FAIL reset_wrcount got %h want 0000", bus.wrcount); end
    vectors++; if (bus.bytecount !== 16'h0) begin miscompares++; $display("FAIL reset_bytecount got %h want 0000", bus.bytecount); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write();
    int t;
    logic [7:0] eb[3];
    eb = '{8'hBE, 8'hEF, 8'h02};
    clear_q();
    send_cmd(40'h02_1234_BEEF, 5, t);
    wait_frames(3, "write");
    vectors++; if (w_t.size() != 1) begin miscompares++; $display("FAIL write_pulses got %0d want 1", w_t.size()); end
    if (w_t.size() >= 1) begin
      vectors++; if (w_t[0] != t + 1) begin miscompares++; $display("FAIL write_wr_cycle got %0d want %0d", w_t[0], t + 1); end
      vectors++; if (w_a[0] !== 16'h1234) begin miscompares++; $display("FAIL write_addr got %h want 1234", w_a[0]); end
      vectors++; if (w_d[0] !== 16'hBEEF) begin miscompares++; $display("FAIL write_wrdata got %h want beef", w_d[0]); end
    end
    vectors++; if (bus.wrcount !== 16'd1) begin miscompares++; $display("FAIL write_wrcount got %h want 0001", bus.wrcount); end
    vectors++; if (bus.bytecount !== 16'd5) begin miscompares++; $display("FAIL write_bytecount got %h want 0005", bus.bytecount); end
    vectors++; if (q_b.size() != 3) begin miscompares++; $display("FAIL write_nframes got %0d want 3", q_b.size()); end
    for (int i = 0; i < 3 && i < q_b.size(); i++) begin
      vectors++; if (q_b[i] !== eb[i] || q_l[i] !== (i == 2)) begin miscompares++; $display("FAIL write_frame%0d got %h/%b want %h/%b", i, q_b[i], q_l[i], eb[i], (i == 2)); end
      vectors++; if (q_t[i] != t + 3 + i*FSTRIDE) begin miscompares++; $display("FAIL write_start%0d got %0d want %0d", i, q_t[i], t + 3 + i*FSTRIDE); end
    end
  endtask

  task automatic test_read();
    int t;
    logic [7:0] eb[3];
    eb = '{8'hBE, 8'hEF, 8'h01};
    clear_q();
    send_cmd(40'h01_1234_0000, 5, t);
    wait_frames(3, "read");
    vectors++; if (w_t.size() != 0) begin miscompares++; $display("FAIL read_wr_pulses got %0d want 0", w_t.size()); end
    vectors++; if (bus.rdcount !== 16'd1) begin miscompares++; $display("FAIL read_rdcount got %h want 0001", bus.rdcount); end
    vectors++; if (bus.wrcount !== 16'd1) begin miscompares++; $display("FAIL read_wrcount got %h want 0001", bus.wrcount); end
    vectors++; if (q_b.size() != 3) begin miscompares++; $display("FAIL read_nframes got %0d want 3", q_b.size()); end
    for (int i = 0; i < 3 && i < q_b.size(); i++) begin
      vectors++; if (q_b[i] !== eb[i] || q_l[i] !== (i == 2)) begin miscompares++; $display("FAIL read_frame%0d got %h/%b want %h/%b", i, q_b[i], q_l[i], eb[i], (i == 2)); end
      vectors++; if (q_t[i] != t + 3 + i*FSTRIDE) begin miscompares++; $display("FAIL read_start%0d got %0d want %0d", i, q_t[i], t + 3 + i*FSTRIDE); end
    end
  endtask

  task automatic test_errors();
    int t;
    logic [7:0] eb[6];
    eb = '{8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h40};
    clear_q();
    send_cmd(40'h01_0005_0000, 4, t);
    wait_frames(3, "err_short");
    send_cmd(40'h07_0005_0000, 5, t);
    wait_frames(6, "err_opcode");
    vectors++; if (q_b.size() != 6) begin miscompares++; $display("FAIL err_nframes got %0d want 6", q_b.size()); end
    for (int i = 0; i < 6 && i < q_b.size(); i++) begin
      vectors++; if (q_b[i] !== eb[i] || q_l[i] !== (i % 3 == 2)) begin miscompares++; $display("FAIL err_frame%0d got %h/%b want %h/%b", i, q_b[i], q_l[i], eb[i], (i % 3 == 2)); end
    end
    vectors++; if (w_t.size() != 0) begin miscompares++; $display("FAIL err_wr_pulses got %0d want 0", w_t.size()); end
    vectors++; if (bus.addr !== 16'h1234) begin miscompares++; $display("FAIL err_addr got %h want 1234", bus.addr); end
    vectors++; if (bus.rdcount !== 16'd1) begin miscompares++; $display("FAIL err_rdcount got %h want 0001", bus.rdcount); end
    vectors++; if (bus.bytecount !== 16'd19) begin miscompares++; $display("FAIL err_bytecount got %h want 0013", bus.bytecount); end
  endtask

  task automatic test_back_to_back();
    int ta, tx, tc;
    logic [7:0] eb[6];
    eb = '{8'hFF, 8'hEF, 8'h01, 8'hFF, 8'hBF, 8'h21};
    clear_q();
    send_cmd(40'h01_0010_0000, 5, ta);
    send_cmd(40'h01_0000_0000, 1, tx);
    send_cmd(40'h01_0040_0000, 5, tc);
    wait_frames(6, "overlap");
    vectors++; if (q_b.size() != 6) begin miscompares++; $display("FAIL overlap_nframes got %0d want 6", q_b.size()); end
    for (int i = 0; i < 6 && i < q_b.size(); i++) begin
      vectors++; if (q_b[i] !== eb[i] || q_l[i] !== (i % 3 == 2)) begin miscompares++; $display("FAIL overlap_frame%0d got %h/%b want %h/%b", i, q_b[i], q_l[i], eb[i], (i % 3 == 2)); end
    end
    if (q_t.size() >= 4) begin
      vectors++; if (q_t[0] != ta + 3) begin miscompares++; $display("FAIL overlap_start0 got %0d want %0d", q_t[0], ta + 3); end
      vectors++; if (q_t[3] != ta + 3 + 3*FSTRIDE + 3) begin miscompares++; $display("FAIL overlap_start3 got %0d want %0d", q_t[3], ta + 3 + 3*FSTRIDE + 3); end
    end
    vectors++; if (bus.rdcount !== 16'd3) begin miscompares++; $display("FAIL overlap_rdcount got %h want 0003", bus.rdcount); end
    vectors++; if (bus.addr !== 16'h0040) begin miscompares++; $display("FAIL overlap_addr got %h want 0040", bus.addr); end
  endtask

  task automatic test_reset_mid();
    int t, g;
    logic [7:0] eb[3];
    eb = '{8'hBE, 8'hEF, 8'h01};
    clear_q();
    send_cmd(40'h01_1234_0000, 5, t);
    g = 0;
    while (cyc < t + 3 + FSTRIDE + 4 && g < 200) begin
      @(negedge clk);
      g++;
    end
    vectors++; if (bus.serialout !== 1'b1) begin miscompares++; $display("FAIL rstmid_before got %b want 1", bus.serialout); end
    rst = 1'b1;
    #1;
    vectors++; if (bus.serialout !== 1'b0) begin miscompares++; $display("FAIL rstmid_serialout got %b want 0", bus.serialout); end
    vectors++; if (bus.rdcount !== 16'd0 || bus.wrcount !== 16'd0 || bus.bytecount !== 16'd0) begin miscompares++; $display("FAIL rstmid_counters got %h/%h/%h want 0000/0000/0000", bus.rdcount, bus.wrcount, bus.bytecount); end
    vectors++; if (bus.addr !== 16'h0) begin miscompares++; $display("FAIL rstmid_addr got %h want 0000", bus.addr); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_q();
    send_cmd(40'h01_1234_0000, 5, t);
    wait_frames(3, "rstmid_fresh");
    vectors++; if (q_b.size() != 3) begin miscompares++; $display("FAIL rstmid_nframes got %0d want 3", q_b.size()); end
    for (int i = 0; i < 3 && i < q_b.size(); i++) begin
      vectors++; if (q_b[i] !== eb[i] || q_l[i] !== (i == 2) || q_t[i] != t + 3 + i*FSTRIDE) begin miscompares++; $display("FAIL rstmid_frame%0d got %h/%b@%0d want %h/%b@%0d", i, q_b[i], q_l[i], q_t[i], eb[i], (i == 2), t + 3 + i*FSTRIDE); end
    end
    vectors++; if (bus.rdcount !== 16'd1 || bus.bytecount !== 16'd5) begin miscompares++; $display("FAIL rstmid_counts got %h/%h want 0001/0005", bus.rdcount, bus.bytecount); end
  endtask

  task automatic test_wrap();
    int t;
    clear_q();
    @(negedge clk);
    force dut.bytecount_q = 16'hFFFE;
    @(negedge clk);
    release dut.bytecount_q;
    @(negedge clk);
    vectors++; if (bus.bytecount !== 16'hFFFE) begin miscompares++; $display("FAIL wrap_preload got %h want fffe", bus.bytecount); end
    send_cmd(40'h02_0050_1234, 5, t);
    wait_frames(3, "wrap");
    vectors++; if (bus.bytecount !== 16'h0003) begin miscompares++; $display("FAIL wrap_bytecount got %h want 0003", bus.bytecount); end
    vectors++; if (w_t.size() != 1) begin miscompares++; $display("FAIL wrap_pulses got %0d want 1", w_t.size()); end
    if (w_t.size() >= 1) begin
      vectors++; if (w_a[0] !== 16'h0050 || w_d[0] !== 16'h1234) begin miscompares++; $display("FAIL wrap_bus got %h/%h want 0050/1234", w_a[0], w_d[0]); end
    end
    if (q_b.size() >= 3) begin
      vectors++; if (q_b[0] !== 8'h12 || q_b[1] !== 8'h34 || q_b[2] !== 8'h02) begin miscompares++; $display("FAIL wrap_resp got %h %h %h want 12 34 02", q_b[0], q_b[1], q_b[2]); end
    end
    vectors++; if (bus.wrcount !== 16'd1) begin miscompares++; $display("FAIL wrap_wrcount got %h want 0001", bus.wrcount); end
  endtask

  initial begin
    rst = 1'b1;
    bus.serialin = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
